// File: rtl/rx_sync_ctrl_pkg.sv
// Shared receive-alignment constants: comma symbol, lane FSM encoding and default limits.
package rx_sync_ctrl_pkg;

    localparam logic [7:0]  COMMA_DEF     = 8'hBC;
    localparam int unsigned SYNC_CNT_DEF  = 4;
    localparam int unsigned ERR_LIMIT_DEF = 4;
    localparam int unsigned CNT_W         = 4;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_SYNC   = 2'd2
    } lane_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/rx_lane_sync.sv
// Per-lane comma alignment FSM with registered byte pass-through and gated valid.
// All outputs registered, 1-cycle latency; drop_o is a same-cycle SYNC->SEARCH indication.
module rx_lane_sync
    import rx_sync_ctrl_pkg::*;
#(
    parameter logic [7:0]  COMMA     = COMMA_DEF,
    parameter int unsigned SYNC_CNT  = SYNC_CNT_DEF,
    parameter int unsigned ERR_LIMIT = ERR_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       sync,
    output logic       drop_o
);

    localparam logic [CNT_W-1:0] SYNC_LIM = CNT_W'(SYNC_CNT);
    localparam logic [CNT_W-1:0] ERR_LIM  = CNT_W'(ERR_LIMIT);

    lane_state_e      state_q, state_d;
    logic [CNT_W-1:0] comma_cnt_q, comma_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             sync_q;
    logic             is_comma;

    assign is_comma = valid_in && (data_in == COMMA);

    always_comb begin
        state_d     = state_q;
        comma_cnt_d = comma_cnt_q;
        err_cnt_d   = err_cnt_q;
        unique case (state_q)
            ST_SEARCH: begin
                if (is_comma) begin
                    if (SYNC_LIM == 4'd1) begin
                        state_d     = ST_SYNC;
                        comma_cnt_d = '0;
                    end else begin
                        state_d     = ST_ALIGN;
                        comma_cnt_d = 4'd1;
                    end
                end
            end
            ST_ALIGN: begin
                if (is_comma) begin
                    comma_cnt_d = sat_inc(comma_cnt_q);
                    if (comma_cnt_d >= SYNC_LIM) begin
                        state_d     = ST_SYNC;
                        comma_cnt_d = '0;
                    end
                end else if (valid_in) begin
                    state_d     = ST_SEARCH;
                    comma_cnt_d = '0;
                end
            end
            ST_SYNC: begin
                if (valid_in) begin
                    err_cnt_d = '0;
                end else begin
                    err_cnt_d = sat_inc(err_cnt_q);
                    if (err_cnt_d >= ERR_LIM) begin
                        state_d   = ST_SEARCH;
                        err_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d     = ST_SEARCH;
                comma_cnt_d = '0;
                err_cnt_d   = '0;
            end
        endcase
    end

    // Valid is qualified by the state held before this edge, so the acquiring comma never passes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SEARCH;
            comma_cnt_q <= '0;
            err_cnt_q   <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            comma_cnt_q <= comma_cnt_d;
            err_cnt_q   <= err_cnt_d;
            data_q      <= data_in;
            valid_q     <= (state_q == ST_SYNC) && valid_in && (data_in != COMMA);
            sync_q      <= (state_d == ST_SYNC);
        end
    end

    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign sync      = sync_q;
    assign drop_o    = (state_q == ST_SYNC) && (state_d == ST_SEARCH);

endmodule

// File: rtl/rx_sync_ctrl.sv
// Two-lane receive sync controller between deserializer and byte-to-word packer.
// 1-cycle registered outputs; link_up lags lane sync by one further cycle.
module rx_sync_ctrl
    import rx_sync_ctrl_pkg::*;
#(
    parameter logic [7:0]  COMMA     = COMMA_DEF,
    parameter int unsigned SYNC_CNT  = SYNC_CNT_DEF,
    parameter int unsigned ERR_LIMIT = ERR_LIMIT_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in_lane0,
    input  logic [7:0] data_in_lane1,
    input  logic       valid_in_lane0,
    input  logic       valid_in_lane1,
    output logic [7:0] data_out_lane0,
    output logic [7:0] data_out_lane1,
    output logic       valid_out_lane0,
    output logic       valid_out_lane1,
    output logic       sync_lane0,
    output logic       sync_lane1,
    output logic       link_up,
    output logic       sync_loss
);

    logic drop0, drop1;
    logic link_up_q, sync_loss_q;

    rx_lane_sync #(.COMMA(COMMA), .SYNC_CNT(SYNC_CNT), .ERR_LIMIT(ERR_LIMIT)) u_lane0 (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in_lane0),
        .valid_in  (valid_in_lane0),
        .data_out  (data_out_lane0),
        .valid_out (valid_out_lane0),
        .sync      (sync_lane0),
        .drop_o    (drop0)
    );

    rx_lane_sync #(.COMMA(COMMA), .SYNC_CNT(SYNC_CNT), .ERR_LIMIT(ERR_LIMIT)) u_lane1 (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in_lane1),
        .valid_in  (valid_in_lane1),
        .data_out  (data_out_lane1),
        .valid_out (valid_out_lane1),
        .sync      (sync_lane1),
        .drop_o    (drop1)
    );

    // A simultaneous drop on both lanes merges into one pulse; reset suppresses it entirely.
    always_ff @(posedge clk) begin
        if (reset) begin
            link_up_q   <= 1'b0;
            sync_loss_q <= 1'b0;
        end else begin
            link_up_q   <= sync_lane0 && sync_lane1;
            sync_loss_q <= drop0 || drop1;
        end
    end

    assign link_up   = link_up_q;
    assign sync_loss = sync_loss_q;

endmodule
